// File: rtl/cdi_video_pkg.sv
// rtl/cdi_video_pkg.sv - shared video types: line fetch states and VRAM address width
package cdi_video_pkg;

  localparam int VRAM_ADDR_W = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } line_fetch_state_t;

endpackage

// File: rtl/line_fetch_if.sv
// rtl/line_fetch_if.sv - memory read handshake and pixel pop port of line_fetch
interface line_fetch_if
  import cdi_video_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;
  logic              pix_pop;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              underrun;

  modport master (
    output mem_req, mem_addr, pix_data, pix_valid, underrun,
    input  mem_ack, mem_data, pix_pop
  );

  modport slave (
    input  mem_req, mem_addr, pix_data, pix_valid, underrun,
    output mem_ack, mem_data, pix_pop
  );
endinterface

// File: rtl/line_fifo.sv
// rtl/line_fifo.sv - show-ahead synchronous FIFO with flush; head reads 0 when empty
module line_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && !flush && (count_q != '0);
    do_push  = push && !flush && ((count_q != FULL) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
endmodule

// File: rtl/line_fetch.sv
// rtl/line_fetch.sv - per-line video word prefetcher into a pixel FIFO
// LINE_FETCH_STATS_EN adds a saturating per-frame underrun counter.
module line_fetch
  import cdi_video_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_frame,
  input  logic              new_line,
  input  logic [8:0]        first_line,
  input  logic [8:0]        num_lines,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [8:0]        line_words,
  input  logic [9:0]        line_stride,
  line_fetch_if.master      bus,
  output logic              busy,
  output logic [15:0]       underrun_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  line_fetch_state_t state_q, state_d;
  logic [8:0]        line_cnt_q, line_cnt_d, remaining_q, remaining_d;
  logic [8:0]        pend_words_q, pend_words_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d, addr_q, addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d, start_addr;
  logic              req_q, req_d, underrun_q, underrun_d, pend_vis_q, pend_vis_d;
  logic              flush, acked, outstanding, start_go, push;
  logic [9:0]        vis_end;
  logic [CW-1:0]     fifo_count;

  line_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (bus.pix_pop),
    .flush     (flush),
    .push_data (bus.mem_data),
    .head_data (bus.pix_data),
    .count     (fifo_count)
  );

  always_comb begin
    flush       = new_line | new_frame;
    acked       = req_q & bus.mem_ack;
    outstanding = req_q & ~bus.mem_ack;

    line_cnt_d = line_cnt_q;
    if (new_frame)                           line_cnt_d = '0;
    else if (new_line && line_cnt_q != '1)   line_cnt_d = line_cnt_q + 9'd1;

    vis_end    = {1'b0, first_line} + {1'b0, num_lines};
    start_go   = (line_cnt_d >= first_line) && ({1'b0, line_cnt_d} < vis_end) &&
                 (line_words != '0);
    start_addr = new_frame ? frame_base : line_addr_q;

    line_addr_d = start_addr;
    if (flush && start_go) line_addr_d = start_addr + ADDR_W'(line_stride);

    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    pend_vis_d   = pend_vis_q;
    pend_words_d = pend_words_q;
    pend_addr_d  = pend_addr_q;
    push         = 1'b0;
    underrun_d   = bus.pix_pop && (fifo_count == '0) && !flush;

    if (flush) begin
      // A request still in flight must be acked before the new line may fetch.
      if (outstanding) begin
        state_d      = DRAIN;
        pend_vis_d   = start_go;
        pend_words_d = line_words;
        pend_addr_d  = start_addr;
      end else if (start_go) begin
        state_d     = FETCH;
        remaining_d = line_words;
        addr_d      = start_addr;
        req_d       = 1'b1;
      end else begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          push = acked;
          if (acked) begin
            remaining_d = remaining_q - 9'd1;
            addr_d      = addr_q + ADDR_W'(1);
          end
          if (!outstanding) begin
            req_d = (remaining_d != '0) && ((fifo_count + CW'(push)) < CW'(DEPTH));
            if (remaining_d == '0) state_d = IDLE;
          end
        end
        DRAIN: begin
          if (acked) begin
            if (pend_vis_q) begin
              state_d     = FETCH;
              remaining_d = pend_words_q;
              addr_d      = pend_addr_q;
              req_d       = 1'b1;
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end
        default: req_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_cnt_q   <= '0;
      line_addr_q  <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      underrun_q   <= 1'b0;
      pend_vis_q   <= 1'b0;
      pend_words_q <= '0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_cnt_q   <= line_cnt_d;
      line_addr_q  <= line_addr_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      underrun_q   <= underrun_d;
      pend_vis_q   <= pend_vis_d;
      pend_words_q <= pend_words_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.pix_valid = (fifo_count != '0);
  assign bus.underrun  = underrun_q;
  assign busy          = (state_q != IDLE);

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] urc_q, urc_d;

  always_comb begin
    urc_d = urc_q;
    if (new_frame)                          urc_d = {15'd0, underrun_d};
    else if (underrun_d && urc_q != '1)     urc_d = urc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) urc_q <= '0;
    else          urc_q <= urc_d;
  end

  assign underrun_count = urc_q;
`else
  assign underrun_count = '0;
`endif
endmodule

// File: tb/tb_line_fetch.sv
// tb/tb_line_fetch.sv - directed self-checking bench for line_fetch
module tb_line_fetch;
  import cdi_video_pkg::*;

`ifdef LINE_FETCH_STATS_EN
  localparam logic [15:0] EXP_URC = 16'd3;
`else
  localparam logic [15:0] EXP_URC = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, new_frame, new_line;
  logic [8:0]  first_line, num_lines, line_words;
  logic [21:0] frame_base;
  logic [9:0]  line_stride;
  logic        busy;
  logic [15:0] underrun_count;
  logic        inst_ack, man_ack;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [21:0] acks [$];

  always #5 clk = ~clk;

  line_fetch_if #(.ADDR_W(VRAM_ADDR_W)) bus ();

  assign bus.mem_ack  = inst_ack ? bus.mem_req : man_ack;
  assign bus.mem_data = bus.mem_addr[15:0];

  line_fetch #(.DEPTH(16), .ADDR_W(VRAM_ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .new_frame      (new_frame),
    .new_line       (new_line),
    .first_line     (first_line),
    .num_lines      (num_lines),
    .frame_base     (frame_base),
    .line_words     (line_words),
    .line_stride    (line_stride),
    .bus            (bus),
    .busy           (busy),
    .underrun_count (underrun_count)
  );

  always @(posedge clk) if (bus.mem_req && bus.mem_ack) acks.push_back(bus.mem_addr);

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; new_frame = 0; new_line = 0; bus.pix_pop = 0;
    first_line = 0; num_lines = 0; line_words = 0; frame_base = 0; line_stride = 0;
    inst_ack = 0; man_ack = 0;
    cycles(3);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 22'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus.mem_addr); end
    n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.pix_valid); end
    n_checks++; if (bus.pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.pix_data); end
    n_checks++; if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b exp 0", bus.underrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (underrun_count !== 16'h0) begin n_fail++; $display("FAIL reset_urc got %h exp 0", underrun_count); end
  endtask

  task automatic test_basic_fetch;
    cycles(1);
    frame_base = 22'h1000; first_line = 0; num_lines = 2; line_words = 4; line_stride = 8;
    inst_ack = 1; acks.delete();
    new_frame = 1; new_line = 1;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL req_in_strobe_cycle got %b exp 0", bus.mem_req); end
    cycles(1);
    new_frame = 0; new_line = 0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h1000) begin
      n_fail++; $display("FAIL first_req got req=%b addr=%h exp 1/001000", bus.mem_req, bus.mem_addr); end
    n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL valid_before_ack got %b exp 0", bus.pix_valid); end
    cycles(1);
    @(negedge clk);
    n_checks++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== 16'h1000) begin
      n_fail++; $display("FAIL ack_to_head got v=%b d=%h exp 1/1000", bus.pix_valid, bus.pix_data); end
    cycles(8);
    n_checks++; if (acks.size() != 4) begin n_fail++; $display("FAIL line0_ack_count got %0d exp 4", acks.size()); end
    for (int i = 0; i < 4 && i < acks.size(); i++) begin
      n_checks++; if (acks[i] !== 22'(22'h1000 + i)) begin
        n_fail++; $display("FAIL line0_addr[%0d] got %h exp %h", i, acks[i], 22'(22'h1000 + i)); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL line0_busy_end got %b exp 0", busy); end

    acks.delete(); new_line = 1; cycles(1); new_line = 0; cycles(8);
    n_checks++; if (acks.size() != 4) begin n_fail++; $display("FAIL line1_ack_count got %0d exp 4", acks.size()); end
    for (int i = 0; i < 4 && i < acks.size(); i++) begin
      n_checks++; if (acks[i] !== 22'(22'h1008 + i)) begin
        n_fail++; $display("FAIL line1_addr[%0d] got %h exp %h", i, acks[i], 22'(22'h1008 + i)); end
    end
    bus.pix_pop = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (bus.pix_data !== 16'(16'h1008 + i)) begin
        n_fail++; $display("FAIL pop_order[%0d] got %h exp %h", i, bus.pix_data, 16'(16'h1008 + i)); end
      cycles(1);
    end
    bus.pix_pop = 0;
    @(negedge clk);
    n_checks++; if (bus.pix_valid !== 1'b0 || bus.underrun !== 1'b0) begin
      n_fail++; $display("FAIL after_pops got v=%b u=%b exp 0/0", bus.pix_valid, bus.underrun); end

    acks.delete(); cycles(1); new_line = 1; cycles(1); new_line = 0; cycles(6);
    n_checks++; if (acks.size() != 0 || bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL line2_invisible got acks=%0d req=%b busy=%b exp 0/0/0", acks.size(), bus.mem_req, busy); end
  endtask

  task automatic test_fifo_full;
    frame_base = 22'h2000; line_words = 20; acks.delete();
    new_frame = 1; new_line = 1; cycles(1); new_frame = 0; new_line = 0;
    cycles(30);
    @(negedge clk);
    n_checks++; if (acks.size() != 16) begin n_fail++; $display("FAIL full_ack_count got %0d exp 16", acks.size()); end
    n_checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL full_stall got req=%b busy=%b exp 0/1", bus.mem_req, busy); end
    n_checks++; if (bus.pix_data !== 16'h2000) begin n_fail++; $display("FAIL full_head got %h exp 2000", bus.pix_data); end
    cycles(1);
    bus.pix_pop = 1; cycles(4); bus.pix_pop = 0; cycles(15);
    @(negedge clk);
    n_checks++; if (acks.size() != 20) begin n_fail++; $display("FAIL refill_ack_count got %0d exp 20", acks.size()); end
    n_checks++; if (acks.size() == 20 && acks[19] !== 22'h2013) begin
      n_fail++; $display("FAIL refill_last_addr got %h exp 002013", acks[19]); end
    n_checks++; if (busy !== 1'b0 || bus.pix_data !== 16'h2004) begin
      n_fail++; $display("FAIL refill_end got busy=%b head=%h exp 0/2004", busy, bus.pix_data); end
  endtask

  task automatic test_drain;
    cycles(1);
    frame_base = 22'h3000; line_words = 2; inst_ack = 0; man_ack = 0; acks.delete();
    new_frame = 1; new_line = 1; cycles(1); new_frame = 0; new_line = 0;
    cycles(2);
    new_line = 1; cycles(1); new_line = 0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h3000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_hold got req=%b addr=%h busy=%b exp 1/003000/1", bus.mem_req, bus.mem_addr, busy); end
    cycles(1);
    man_ack = 1; cycles(1); man_ack = 0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h3008) begin
      n_fail++; $display("FAIL drain_refetch got req=%b addr=%h exp 1/003008", bus.mem_req, bus.mem_addr); end
    n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard got valid=%b exp 0", bus.pix_valid); end
    inst_ack = 1; cycles(4);
    @(negedge clk);
    n_checks++; if (acks.size() != 3) begin n_fail++; $display("FAIL drain_ack_count got %0d exp 3", acks.size()); end
    else begin
      n_checks++; if (acks[0] !== 22'h3000 || acks[1] !== 22'h3008 || acks[2] !== 22'h3009) begin
        n_fail++; $display("FAIL drain_addrs got %h %h %h exp 003000 003008 003009", acks[0], acks[1], acks[2]); end
    end
    n_checks++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== 16'h3008) begin
      n_fail++; $display("FAIL drain_head got v=%b d=%h exp 1/3008", bus.pix_valid, bus.pix_data); end
  endtask

  task automatic test_underrun;
    cycles(1);
    first_line = 5; new_frame = 1; new_line = 1; cycles(1); new_frame = 0; new_line = 0;
    cycles(2);
    @(negedge clk);
    n_checks++; if (bus.pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ur_setup got v=%b busy=%b exp 0/0", bus.pix_valid, busy); end
    cycles(1);
    for (int k = 0; k < 3; k++) begin
      bus.pix_pop = 1; cycles(1); bus.pix_pop = 0;
      @(negedge clk);
      n_checks++; if (bus.underrun !== 1'b1) begin n_fail++; $display("FAIL ur_pulse[%0d] got %b exp 1", k, bus.underrun); end
      cycles(1);
      @(negedge clk);
      n_checks++; if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL ur_single[%0d] got %b exp 0", k, bus.underrun); end
      cycles(1);
    end
    n_checks++; if (underrun_count !== EXP_URC) begin
      n_fail++; $display("FAIL ur_count got %0d exp %0d", underrun_count, EXP_URC); end
    new_frame = 1; new_line = 1; bus.pix_pop = 1; cycles(1);
    new_frame = 0; new_line = 0; bus.pix_pop = 0;
    @(negedge clk);
    n_checks++; if (bus.underrun !== 1'b0 || underrun_count !== 16'h0) begin
      n_fail++; $display("FAIL ur_flush_wins got u=%b cnt=%0d exp 0/0", bus.underrun, underrun_count); end
  endtask

  task automatic test_reset_mid_handshake;
    cycles(1);
    first_line = 0; frame_base = 22'h4000; line_words = 20; inst_ack = 1; acks.delete();
    new_frame = 1; new_line = 1; cycles(1); new_frame = 0; new_line = 0;
    for (int i = 0; i < 50 && acks.size() < 5; i++) @(negedge clk);
    inst_ack = 0; man_ack = 0;
    n_checks++; if (acks.size() != 5) begin n_fail++; $display("FAIL rst_setup_acks got %0d exp 5", acks.size()); end
    n_checks++; if (bus.mem_req !== 1'b1 || bus.pix_valid !== 1'b1 || bus.mem_addr !== 22'h4005) begin
      n_fail++; $display("FAIL rst_setup got req=%b v=%b addr=%h exp 1/1/004005", bus.mem_req, bus.pix_valid, bus.mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 22'h0) begin
      n_fail++; $display("FAIL rst_async_req got req=%b addr=%h exp 0/0", bus.mem_req, bus.mem_addr); end
    n_checks++; if (bus.pix_valid !== 1'b0 || bus.pix_data !== 16'h0 || bus.underrun !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_pix got v=%b d=%h u=%b exp 0/0/0", bus.pix_valid, bus.pix_data, bus.underrun); end
    n_checks++; if (busy !== 1'b0 || underrun_count !== 16'h0) begin
      n_fail++; $display("FAIL rst_async_misc got busy=%b cnt=%0d exp 0/0", busy, underrun_count); end
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_fifo_full();
    test_drain();
    test_underrun();
    test_reset_mid_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/line_fetch.md
# line_fetch

Per-line pixel word prefetcher sitting directly downstream of the video timing generator. It counts lines from the timing strobes and, at the start of each visible line, fetches a programmable number of 16-bit words from video memory over a req/ack handshake into a small FIFO. The pixel decoder pops that FIFO on its pixel strobe. Underrun is flagged when a pop finds the FIFO empty.

## Interface
- `DEPTH`, 16: FIFO depth in words; power of two, ≥4.
- `ADDR_W`, 22: word address width.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `new_frame` in 1: one-cycle frame-start strobe from timing.
- `new_line` in 1: one-cycle line-start strobe; coincides with `new_frame` at frame start.
- `first_line` in 9: first visible line index (counted from frame start).
- `num_lines` in 9: number of visible lines.
- `frame_base` in ADDR_W: word address of line 0; sampled on `new_frame`.
- `line_words` in 9: words fetched per visible line, 0..384; sampled on fetch start.
- `line_stride` in 10: address increment per visible line.
- `mem_req` out 1: read request.
- `mem_addr` out ADDR_W: request word address.
- `mem_ack` in 1: request accepted, `mem_data` valid this cycle.
- `mem_data` in 16: read data.
- `pix_pop` in 1: consume head word.
- `pix_data` out 16: FIFO head (show-ahead), 0 when empty.
- `pix_valid` out 1: FIFO not empty.
- `underrun` out 1: one-cycle pulse on pop while empty.
- `busy` out 1: fetch or drain in progress.
- `underrun_count` out 16: see Configuration.

## Operation
- Line counter: cleared to 0 on `new_frame`; incremented on `new_line` without `new_frame`. Saturates at 511.
- Line address register: loaded with `frame_base` on `new_frame`. Advances by `line_stride` after each visible-line fetch start (9/10-bit zero-extended, wraps modulo 2^ADDR_W).
- Visible line: `first_line ≤ cnt < first_line+num_lines`. The sum is computed 10 bits wide, no wrap.
- States:
  - IDLE: waiting for a line start.
  - FETCH: issuing requests until `remaining` reaches 0.
  - DRAIN: an outstanding request has been made stale; its ack is awaited and its data discarded.
- On `new_line` (or `new_frame`):
  - FIFO is flushed.
  - If a request is outstanding, go to DRAIN.
  - Otherwise, if the new line is visible and `line_words≠0`, load `remaining`, set `mem_addr` to the line address, and go to FETCH. Otherwise go to IDLE.
- FETCH:
  - `mem_req` asserts when `remaining>0` and `count + pending < DEPTH`.
  - Once asserted, `mem_req` and `mem_addr` stay stable until `mem_ack`.
  - On ack: push `mem_data`, `mem_addr+1`, `remaining-1`. `mem_req` may stay high back-to-back if space remains.
  - At `remaining==0`, go to IDLE.
- DRAIN:
  - On ack, discard the data.
  - If the pending line start was for a visible line, go to FETCH for that line (start latched in DRAIN). Otherwise go to IDLE.
  - A further `new_line` while in DRAIN replaces the latched start.
- Pop:
  - `pix_pop` with FIFO non-empty removes the head.
  - `pix_pop` with FIFO empty: no state change, `underrun` pulses.
- Flush and pop in the same cycle: flush wins, no underrun pulse.
- Push and pop in the same cycle: count unchanged.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `pix_data`=0, `pix_valid`=0, `underrun`=0, `busy`=0, `underrun_count`=0, line counter=0, state IDLE, FIFO empty.
- `mem_req` rises at the earliest 1 cycle after the `new_line` strobe.
- A word acked in cycle t is on `pix_data` with `pix_valid`=1 in cycle t+1.
- `underrun` is registered: it pulses in cycle t+1 for a pop in cycle t.
- `reset_n` low mid-handshake drops `mem_req` immediately and asynchronously. The memory side must tolerate an abandoned request.

## Configuration
- `LINE_FETCH_STATS_EN` defined:
  - `underrun_count` is a saturating 16-bit counter of underrun events.
  - It is cleared on `new_frame`.
  - If a clear and an increment occur in the same cycle, the result is 1.
- `LINE_FETCH_STATS_EN` undefined: `underrun_count` is tied to 0 and no counter logic is synthesized. `underrun` is unaffected.

## Structure
- Shared package `cdi_video_pkg`: `line_fetch_state_t` enum (IDLE, FETCH, DRAIN) and the `VRAM_ADDR_W` constant.
- One sub-module, `line_fifo`:
  - Show-ahead synchronous FIFO with flush.
  - Ports: push, pop, flush, data, count.
  - Depth `DEPTH`.

## Test plan
- Reset, then `frame_base`=0x1000, `first_line`=0, `num_lines`=2, `line_words`=4, `line_stride`=8, instant ack → addresses 0x1000..0x1003 on line 0 and 0x1008..0x100B on line 1; line 2 issues no request.
- `line_words`=20, `DEPTH`=16, no pops → exactly 16 acks, then `mem_req` low; 4 pops → 4 more requests.
- `new_line` while a request is waiting 5 cycles for ack → DRAIN, acked data absent from FIFO, next line's fetch starts after that ack.
- Pop on empty FIFO 3 times in frame, then `new_frame` → 3 `underrun` pulses; `underrun_count`=3 before the frame strobe, 0 after (with `LINE_FETCH_STATS_EN`).
- `reset_n` asserted with `mem_req`=1 and FIFO holding 5 words → all outputs at reset values in the same cycle.
